instruction_sequencer: RTL

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute sequencer that walks a program ROM from address 0.
// A run ends at an OUT instruction or, with overrun set, after MAX_ADDR executes.
module instruction_sequencer #(
  parameter logic [7:0] MAX_ADDR = 8'd15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] prog_sel,
  output logic [1:0] prog,
  output logic [7:0] address,
  input  logic [7:0] instruction,
  output logic [3:0] op,
  output logic [1:0] ra,
  output logic [1:0] rb,
  output logic       alu_en,
  output logic       push_en,
  output logic       lda_en,
  output logic       ldb_en,
  output logic       out_en,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    DONE
  } state_t;

  localparam logic [3:0] OP_OUT = 4'b1011;

  state_t     state, state_nx;
  logic [7:0] ir;
  logic       last_instr;

  assign last_instr = (op == OP_OUT) || (address == MAX_ADDR);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    alu_en   = 1'b0;
    push_en  = 1'b0;
    lda_en   = 1'b0;
    ldb_en   = 1'b0;
    out_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = FETCH;
      end
      FETCH: begin
        busy     = 1'b1;
        state_nx = DECODE;
      end
      DECODE: begin
        busy     = 1'b1;
        state_nx = EXEC;
      end
      EXEC: begin
        busy = 1'b1;
        unique case (op)
          4'b1000:          push_en = 1'b1;
          4'b1001:          lda_en  = 1'b1;
          4'b1010:          ldb_en  = 1'b1;
          4'b1011:          out_en  = 1'b1;
          4'b1110, 4'b1111: ;
          default:          alu_en  = 1'b1;
        endcase
        state_nx = last_instr ? DONE : FETCH;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prog    <= '0;
      address <= '0;
      overrun <= 1'b0;
      ir      <= '0;
      op      <= '0;
      ra      <= '0;
      rb      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            prog    <= prog_sel;
            address <= '0;
            overrun <= 1'b0;
          end
        end
        FETCH: ir <= instruction;
        DECODE: begin
          op <= ir[7:4];
          ra <= ir[3:2];
          rb <= ir[1:0];
        end
        EXEC: begin
          // OUT wins over the address limit, so a final OUT never flags overrun
          if (op != OP_OUT) begin
            if (address == MAX_ADDR) overrun <= 1'b1;
            else                     address <= address + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
